// File: rtl/apb_regbank.sv
// APB register bank: CTRL (start/irq enable), sticky STATUS, and NREG-2 byte-writable
// config registers, with a configurable number of wait states per access.
module apb_regbank #(
  parameter int DW   = 32,
  parameter int NREG = 8,
  parameter int AW   = 32,
  parameter int WAIT = 0
) (
  input  logic                   I_PCLK,
  input  logic                   I_PRESET_N,
  input  logic                   I_PSEL,
  input  logic                   I_PENABLE,
  input  logic                   I_PWRITE,
  input  logic [AW-1:0]          I_PADDR,
  input  logic [DW-1:0]          I_PWDATA,
  input  logic [DW/8-1:0]        I_PSTRB,
  output logic [DW-1:0]          O_PRDATA,
  output logic                   O_PREADY,
  output logic                   O_PSLVERR,
  input  logic [DW-1:0]          I_STATUS,
  input  logic                   I_DONE,
  output logic [(NREG-2)*DW-1:0] O_CFG,
  output logic                   O_START,
  output logic                   O_IRQ
);
  localparam int IW = $clog2(NREG);
  localparam int NB = DW / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state;
  logic [3:0]              wcnt;
  logic [NREG-1:2][DW-1:0] cfg;
  logic                    irq_en, done;
  logic [IW-1:0]           idx;
  logic                    legal, xfer, cmpl, wr, wr_ctrl, wr_stat;
  logic [DW-1:0]           rval;
  logic                    unused;

  assign unused   = I_STATUS[0];
  assign idx      = I_PADDR[IW+1:2];
  assign legal    = (I_PADDR[1:0] == 2'b00) && (I_PADDR < AW'(4 * NREG));
  assign xfer     = I_PSEL & I_PENABLE;
  assign O_PREADY = (state == ACCESS) && (wcnt == 4'd0);
  assign cmpl     = O_PREADY & xfer;
  assign wr       = cmpl & I_PWRITE & legal;
  assign wr_ctrl  = wr & (idx == IW'(0)) & I_PSTRB[0];
  assign wr_stat  = wr & (idx == IW'(1)) & I_PSTRB[0];

  assign O_PRDATA  = (cmpl & ~I_PWRITE & legal) ? rval : '0;
  assign O_PSLVERR = cmpl & ~legal;
  assign O_CFG     = cfg;

  always_comb begin
    rval = '0;
    if (idx == IW'(0)) rval[1] = irq_en;
    else if (idx == IW'(1)) rval = {I_STATUS[DW-1:1], done};
    else
      for (int i = 2; i < NREG; i++)
        if (idx == IW'(i)) rval = cfg[i];
  end

  // State lags the bus by one cycle: SETUP is the first PENABLE cycle.
  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      state <= IDLE;
      wcnt  <= 4'd0;
    end else begin
      case (state)
        IDLE:   if (I_PSEL && !I_PENABLE) state <= SETUP;
        SETUP: begin
          state <= ACCESS;
          wcnt  <= 4'(WAIT);
        end
        ACCESS: begin
          if (!xfer) state <= IDLE;
          else if (O_PREADY) state <= (I_PSEL && !I_PENABLE) ? SETUP : IDLE;
          else wcnt <= wcnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      cfg     <= '0;
      irq_en  <= 1'b0;
      done    <= 1'b0;
      O_START <= 1'b0;
      O_IRQ   <= 1'b0;
    end else begin
      O_START <= wr_ctrl & I_PWDATA[0];
      if (wr_ctrl) irq_en <= I_PWDATA[1];
      // a completion pulse beats a same-cycle clear
      if (I_DONE) done <= 1'b1;
      else if (wr_stat && I_PWDATA[0]) done <= 1'b0;
      O_IRQ <= done & irq_en;
      for (int i = 2; i < NREG; i++)
        for (int b = 0; b < NB; b++)
          if (wr && idx == IW'(i) && I_PSTRB[b]) cfg[i][8*b +: 8] <= I_PWDATA[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_apb_regbank.sv
// Bench for apb_regbank: three instances (WAIT = 0, 3, 5) driven by an APB master task
// and checked against a register-level model.
module tb_apb_regbank;
  localparam int DW = 32, NREG = 8, AW = 32, NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n [NI];
  logic                   psel [NI], penable [NI], pwrite [NI];
  logic [AW-1:0]          paddr [NI];
  logic [DW-1:0]          pwdata [NI];
  logic [DW/8-1:0]        pstrb [NI];
  logic [DW-1:0]          prdata [NI];
  logic                   pready [NI], pslverr [NI];
  logic [DW-1:0]          status [NI];
  logic                   done_in [NI];
  logic [(NREG-2)*DW-1:0] cfg_out [NI];
  logic                   start [NI], irq [NI];

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      apb_regbank #(.DW(DW), .NREG(NREG), .AW(AW), .WAIT(g == 0 ? 0 : (g == 1 ? 3 : 5))) u (
        .I_PCLK(clk), .I_PRESET_N(rst_n[g]), .I_PSEL(psel[g]), .I_PENABLE(penable[g]),
        .I_PWRITE(pwrite[g]), .I_PADDR(paddr[g]), .I_PWDATA(pwdata[g]), .I_PSTRB(pstrb[g]),
        .O_PRDATA(prdata[g]), .O_PREADY(pready[g]), .O_PSLVERR(pslverr[g]),
        .I_STATUS(status[g]), .I_DONE(done_in[g]), .O_CFG(cfg_out[g]),
        .O_START(start[g]), .O_IRQ(irq[g]));
    end
  endgenerate

  int checks = 0, errors = 0;

  // reference model: register contents per instance
  logic [DW-1:0] m_cfg [NI][NREG];
  bit            m_irqen [NI], m_done [NI];

  function automatic int wait_of(input int u);
    return (u == 0) ? 0 : ((u == 1) ? 3 : 5);
  endfunction

  function automatic bit legal(input logic [AW-1:0] a);
    return (a % 4 == 0) && (a < 4 * NREG);
  endfunction

  function automatic void m_reset(input int u);
    for (int i = 0; i < NREG; i++) m_cfg[u][i] = '0;
    m_irqen[u] = 0;
    m_done[u]  = 0;
  endfunction

  function automatic logic [DW-1:0] m_read(input int u, input logic [AW-1:0] a);
    int idx;
    if (!legal(a)) return '0;
    idx = int'(a / 4);
    if (idx == 0) return m_irqen[u] ? DW'(2) : DW'(0);
    if (idx == 1) return (status[u] & ~DW'(1)) | DW'(m_done[u]);
    return m_cfg[u][idx];
  endfunction

  function automatic void m_write(input int u, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                  input logic [DW/8-1:0] s);
    int idx;
    if (!legal(a)) return;
    idx = int'(a / 4);
    if (idx == 0) begin
      if (s[0]) m_irqen[u] = d[1];
    end else if (idx == 1) begin
      if (s[0] && d[0]) m_done[u] = 0;
    end else begin
      for (int k = 0; k < DW / 8; k++)
        if (s[k]) m_cfg[u][idx][8*k +: 8] = d[8*k +: 8];
    end
  endfunction

  function automatic logic [(NREG-2)*DW-1:0] m_cfg_flat(input int u);
    logic [(NREG-2)*DW-1:0] r;
    for (int i = 2; i < NREG; i++) r[(i-2)*DW +: DW] = m_cfg[u][i];
    return r;
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // One APB transfer; entered and left just after a rising edge with the bus idle.
  task automatic apb(input int u, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW/8-1:0] s, input bit dp,
                     output logic [DW-1:0] rd, output logic err, output int lows);
    bit got;
    psel[u] = 1; penable[u] = 0; pwrite[u] = wr; paddr[u] = a; pwdata[u] = d; pstrb[u] = s;
    sync();
    penable[u] = 1;
    lows = 0; got = 0; rd = '0; err = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (pready[u]) begin
        got = 1; rd = prdata[u]; err = pslverr[u];
        if (dp) done_in[u] = 1;
      end else begin
        lows++;
        checks++;
        if (prdata[u] !== '0 || pslverr[u] !== 1'b0) begin
          errors++;
          $display("FAIL early_resp u%0d addr=%h: prdata=%h pslverr=%b, required 0/0 before PREADY",
                   u, a, prdata[u], pslverr[u]);
        end
      end
      sync();
    end
    done_in[u] = 0; psel[u] = 0; penable[u] = 0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout u%0d addr=%h: PREADY never seen, required within 40 cycles", u, a);
    end else begin
      if (wr) m_write(u, a, d, s);
      if (dp) m_done[u] = 1;
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < NI; u++) begin
      rst_n[u] = 0; psel[u] = 0; penable[u] = 0; pwrite[u] = 0; paddr[u] = '0;
      pwdata[u] = '0; pstrb[u] = '0; done_in[u] = 0; status[u] = $urandom;
      m_reset(u);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < NI; u++) begin
      checks++;
      if ({pready[u], pslverr[u], start[u], irq[u]} !== 4'b0 || prdata[u] !== '0 || cfg_out[u] !== '0) begin
        errors++;
        $display("FAIL reset u%0d: pready=%b pslverr=%b start=%b irq=%b prdata=%h cfg=%h, required all 0",
                 u, pready[u], pslverr[u], start[u], irq[u], prdata[u], cfg_out[u]);
      end
    end
    sync();
    for (int u = 0; u < NI; u++) rst_n[u] = 1;
    sync();
  endtask

  task automatic test_basic();
    logic [DW-1:0] rd, exp; logic err; int lows;
    apb(0, 1, 'h08, 'hA5A5A5A5, 'hF, 0, rd, err, lows);
    checks++;
    if (err !== 0 || lows != 1) begin
      errors++; $display("FAIL basic_wr: err=%b lows=%0d, required 0 and 1", err, lows);
    end
    apb(0, 0, 'h08, '0, '0, 0, rd, err, lows);
    checks++;
    if (rd !== 32'hA5A5A5A5 || err !== 0 || lows != 1) begin
      errors++;
      $display("FAIL basic_rd: rd=%h err=%b lows=%0d, required a5a5a5a5 0 1", rd, err, lows);
    end
    for (int a = 0; a < 8; a += 4) begin
      exp = m_read(0, AW'(a));
      apb(0, 0, AW'(a), '0, '0, 0, rd, err, lows);
      checks++;
      if (rd !== exp || err !== 0) begin
        errors++; $display("FAIL basic_ctrl_stat addr=%0h: rd=%h err=%b, required %h 0", a, rd, err, exp);
      end
    end
  endtask

  task automatic test_wait();
    logic [DW-1:0] rd, d; logic err; int lows;
    d = $urandom;
    apb(1, 1, 'h0C, d, 'hF, 0, rd, err, lows);
    apb(1, 0, 'h0C, '0, '0, 0, rd, err, lows);
    checks++;
    if (rd !== d || err !== 0 || lows != 4) begin
      errors++; $display("FAIL wait3_rd: rd=%h err=%b lows=%0d, required %h 0 4", rd, err, lows, d);
    end
  endtask

  task automatic test_strobe_start();
    logic [DW-1:0] rd; logic err; int lows;
    apb(0, 1, 'h10, 'hA5A5A5A5, 'hF, 0, rd, err, lows);
    apb(0, 1, 'h10, 'h11223344, 'h5, 0, rd, err, lows);
    apb(0, 0, 'h10, '0, '0, 0, rd, err, lows);
    checks++;
    if (rd !== 32'hA522A544 || cfg_out[0][2*DW +: DW] !== 32'hA522A544) begin
      errors++;
      $display("FAIL strobe: rd=%h cfg4=%h, required a522a544", rd, cfg_out[0][2*DW +: DW]);
    end
    @(negedge clk);
    checks++;
    if (start[0] !== 1'b0) begin errors++; $display("FAIL start_idle: start=%b, required 0", start[0]); end
    sync();
    apb(0, 1, 'h00, 'h1, 'h1, 0, rd, err, lows);
    @(negedge clk);
    checks++;
    if (start[0] !== 1'b1) begin errors++; $display("FAIL start_pulse: start=%b, required 1", start[0]); end
    @(negedge clk);
    checks++;
    if (start[0] !== 1'b0) begin errors++; $display("FAIL start_width: start=%b, required 0", start[0]); end
    sync();
    apb(0, 0, 'h00, '0, '0, 0, rd, err, lows);
    checks++;
    if (rd !== '0) begin errors++; $display("FAIL ctrl_read: rd=%h, required 0", rd); end
  endtask

  task automatic test_illegal();
    logic [AW-1:0] bad [5];
    logic [DW-1:0] rd, exp; logic err; int lows;
    bad = '{'h20, 'h06, 'h02, 'h1E, 'h100};
    foreach (bad[i]) begin
      apb(0, 1, bad[i], '1, 'hF, 0, rd, err, lows);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL illegal_wr addr=%h: err=%b, required 1", bad[i], err); end
      apb(0, 0, bad[i], '0, '0, 0, rd, err, lows);
      checks++;
      if (err !== 1'b1 || rd !== '0) begin
        errors++; $display("FAIL illegal_rd addr=%h: err=%b rd=%h, required 1 0", bad[i], err, rd);
      end
    end
    for (int a = 0; a < 4 * NREG; a += 4) begin
      exp = m_read(0, AW'(a));
      apb(0, 0, AW'(a), '0, '0, 0, rd, err, lows);
      checks++;
      if (rd !== exp || err !== 0) begin
        errors++; $display("FAIL illegal_side addr=%0h: rd=%h err=%b, required %h 0", a, rd, err, exp);
      end
    end
  endtask

  task automatic test_irq();
    logic [DW-1:0] rd, exp; logic err; int lows;
    apb(0, 1, 'h00, 'h2, 'h1, 0, rd, err, lows);
    done_in[0] = 1;
    sync();
    done_in[0] = 0; m_done[0] = 1;
    @(negedge clk);
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL irq_lag: irq=%b, required 0", irq[0]); end
    @(negedge clk);
    checks++;
    if (irq[0] !== 1'b1) begin errors++; $display("FAIL irq_set: irq=%b, required 1", irq[0]); end
    sync();
    apb(0, 1, 'h04, 'h1, 'h1, 1, rd, err, lows);
    exp = m_read(0, 'h04);
    apb(0, 0, 'h04, '0, '0, 0, rd, err, lows);
    checks++;
    if (rd !== exp || rd[0] !== 1'b1) begin
      errors++; $display("FAIL done_wins: rd=%h, required %h with bit0=1", rd, exp);
    end
    apb(0, 1, 'h04, 'h1, 'h1, 0, rd, err, lows);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL irq_clear: irq=%b, required 0", irq[0]); end
    sync();
    apb(0, 0, 'h04, '0, '0, 0, rd, err, lows);
    checks++;
    if (rd[0] !== 1'b0 || rd !== m_read(0, 'h04)) begin
      errors++; $display("FAIL done_clear: rd=%h, required %h", rd, m_read(0, 'h04));
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] rd, v; logic err; int lows, hits;
    v = $urandom;
    apb(2, 1, 'h08, v, 'hF, 0, rd, err, lows);
    psel[2] = 1; penable[2] = 0; pwrite[2] = 1; paddr[2] = 'h08; pwdata[2] = ~v; pstrb[2] = 'hF;
    sync();
    penable[2] = 1;
    repeat (3) sync();
    psel[2] = 0; penable[2] = 0;
    repeat (2) sync();
    apb(2, 0, 'h08, '0, '0, 0, rd, err, lows);
    checks++;
    if (rd !== v || lows != 6) begin
      errors++; $display("FAIL abort: rd=%h lows=%0d, required %h 6", rd, lows, v);
    end
    psel[2] = 1; penable[2] = 1; pwrite[2] = 1; paddr[2] = 'h08; pwdata[2] = ~v;
    hits = 0;
    repeat (4) begin
      @(negedge clk);
      if (pready[2]) hits++;
    end
    psel[2] = 0; penable[2] = 0;
    sync();
    checks++;
    if (hits != 0) begin errors++; $display("FAIL no_setup: pready cycles=%0d, required 0", hits); end
    apb(2, 0, 'h08, '0, '0, 0, rd, err, lows);
    checks++;
    if (rd !== v) begin errors++; $display("FAIL no_setup_data: rd=%h, required %h", rd, v); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd, c3; logic err; int lows;
    apb(2, 1, 'h0C, $urandom, 'hF, 0, rd, err, lows);
    psel[2] = 1; penable[2] = 0; pwrite[2] = 1; paddr[2] = 'h0C; pwdata[2] = $urandom; pstrb[2] = 'hF;
    sync();
    penable[2] = 1;
    repeat (3) sync();
    rst_n[2] = 0;
    #1;
    checks++;
    if ({pready[2], pslverr[2], start[2], irq[2]} !== 4'b0 || prdata[2] !== '0 || cfg_out[2] !== '0) begin
      errors++;
      $display("FAIL reset_mid: pready=%b pslverr=%b start=%b irq=%b prdata=%h cfg=%h, required all 0",
               pready[2], pslverr[2], start[2], irq[2], prdata[2], cfg_out[2]);
    end
    psel[2] = 0; penable[2] = 0;
    sync();
    rst_n[2] = 1; m_reset(2);
    sync();
    checks++;
    if (cfg_out[2] !== '0) begin errors++; $display("FAIL reset_commit: cfg=%h, required 0", cfg_out[2]); end
    c3 = $urandom;
    apb(2, 1, 'h0C, c3, 'hF, 0, rd, err, lows);
    apb(2, 0, 'h0C, '0, '0, 0, rd, err, lows);
    checks++;
    if (rd !== c3 || err !== 0 || lows != 6) begin
      errors++; $display("FAIL reset_resume: rd=%h err=%b lows=%0d, required %h 0 6", rd, err, lows, c3);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a [6];
    logic [DW-1:0] rd, exp; logic err; int lows;
    foreach (a[i]) begin
      a[i] = AW'(4 * $urandom_range(2, NREG - 1));
      apb(1, 1, a[i], $urandom, 4'($urandom_range(0, 15)), 0, rd, err, lows);
    end
    foreach (a[i]) begin
      exp = m_read(1, a[i]);
      apb(1, 0, a[i], '0, '0, 0, rd, err, lows);
      checks++;
      if (rd !== exp || err !== 0 || lows != 4) begin
        errors++;
        $display("FAIL b2b addr=%h: rd=%h err=%b lows=%0d, required %h 0 4", a[i], rd, err, lows, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a; logic [DW-1:0] d, rd, exp; logic [DW/8-1:0] s; logic err; bit wr, dp, expe;
    int lows;
    for (int u = 0; u < NI; u++) begin
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 3) == 0) status[u] = $urandom;
        a   = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(0, 63)) : AW'(4 * $urandom_range(0, NREG - 1));
        wr  = 1'($urandom_range(0, 1));
        d   = $urandom;
        s   = 4'($urandom_range(0, 15));
        dp  = ($urandom_range(0, 7) == 0);
        exp = wr ? '0 : m_read(u, a);
        expe = !legal(a);
        apb(u, wr, a, d, s, dp, rd, err, lows);
        checks++;
        if (rd !== exp || err !== expe || lows != wait_of(u) + 1) begin
          errors++;
          $display("FAIL rand u%0d wr=%b addr=%h: rd=%h err=%b lows=%0d, required %h %b %0d",
                   u, wr, a, rd, err, lows, exp, expe, wait_of(u) + 1);
        end
        checks++;
        if (cfg_out[u] !== m_cfg_flat(u)) begin
          errors++; $display("FAIL rand_cfg u%0d: cfg=%h, required %h", u, cfg_out[u], m_cfg_flat(u));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_strobe_start();
    test_illegal();
    test_irq();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
